// File: rtl/pad_pkg.sv
// Shared pad-event definitions: button indices, event byte layout, scan FSM states and helpers.
package pad_pkg;

  localparam int NUM_BTN = 12;

  typedef enum logic [3:0] {
    BTN_B      = 4'd0,
    BTN_Y      = 4'd1,
    BTN_SELECT = 4'd2,
    BTN_START  = 4'd3,
    BTN_UP     = 4'd4,
    BTN_DOWN   = 4'd5,
    BTN_LEFT   = 4'd6,
    BTN_RIGHT  = 4'd7,
    BTN_A      = 4'd8,
    BTN_X      = 4'd9,
    BTN_L      = 4'd10,
    BTN_R      = 4'd11
  } btn_idx_e;

  localparam int EVT_PRESS_BIT = 7;
  localparam int EVT_RPT_BIT   = 6;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_SCAN = 1'b1
  } scan_state_e;

  function automatic logic [3:0] lowest_set(input logic [NUM_BTN-1:0] v);
    logic [3:0] r;
    r = 4'd0;
    for (int i = NUM_BTN - 1; i >= 0; i--) begin
      if (v[i]) r = 4'(i);
    end
    return r;
  endfunction

  function automatic logic [7:0] make_evt(input logic press, input logic rpt, input logic [3:0] idx);
    logic [7:0] e;
    e = {4'b0000, idx};
    e[EVT_PRESS_BIT] = press;
    e[EVT_RPT_BIT]   = rpt;
    return e;
  endfunction

endpackage

// File: rtl/pad_evt_fifo.sv
// Event FIFO with registered head: a push is visible on rd_data/empty the cycle after its edge.
// Pushes while full are refused unless a pop lands on the same edge; pops while empty are ignored.
module pad_evt_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr, rd_ptr, wr_ptr_nxt, rd_ptr_nxt;
  logic [WIDTH-1:0] mem [DEPTH];
  logic [WIDTH-1:0] head_nxt;
  logic             do_push, do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign wr_ptr_nxt = wr_ptr + {{AW{1'b0}}, do_push};
  assign rd_ptr_nxt = rd_ptr + {{AW{1'b0}}, do_pop};

  // The new head may be the entry being written on this same edge, so bypass it.
  always_comb begin
    head_nxt = '0;
    if (rd_ptr_nxt == wr_ptr_nxt)
      head_nxt = '0;
    else if (do_push && (rd_ptr_nxt == wr_ptr))
      head_nxt = push_data;
    else
      head_nxt = mem[rd_ptr_nxt[AW-1:0]];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_data <= '0;
    end else begin
      wr_ptr  <= wr_ptr_nxt;
      rd_ptr  <= rd_ptr_nxt;
      rd_data <= head_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr[AW-1:0]] <= push_data;
  end

endmodule

// File: rtl/pad_event_fifo.sv
// Debounces 12 pad buttons and queues press/release events, one per clock in ascending index order.
// Strobes during a scan and events pushed into a full FIFO are lost and flagged; PAD_EVENT_REPEAT_EN adds d-pad auto-repeat.
module pad_event_fifo
  import pad_pkg::*;
#(
  parameter int DEPTH    = 8,
  parameter int DEBOUNCE = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               sample_stb,
  input  logic [NUM_BTN-1:0] btn,
  output logic [NUM_BTN-1:0] btn_state,
  input  logic               rd_en,
  output logic [7:0]         rd_data,
  output logic               empty,
  output logic               overflow,
  input  logic               clr_ovf
);

  localparam logic [3:0] DB_LIMIT = 4'(DEBOUNCE);

  scan_state_e                  state;
  logic [NUM_BTN-1:0][3:0]      agree_cnt, agree_cnt_nxt;
  logic [NUM_BTN-1:0]           toggle, rpt_hit, pending, rpt_flag, clr_mask;
  logic                         accept, evt_push, fifo_full, drop, ovf_set;
  logic [3:0]                   scan_idx;
  logic [7:0]                   evt;

  assign accept = sample_stb && (state == ST_IDLE);

  always_comb begin
    toggle        = '0;
    agree_cnt_nxt = '0;
    for (int i = 0; i < NUM_BTN; i++) begin
      if (btn[i] != btn_state[i]) begin
        if (agree_cnt[i] + 4'd1 == DB_LIMIT)
          toggle[i] = 1'b1;
        else
          agree_cnt_nxt[i] = agree_cnt[i] + 4'd1;
      end
    end
  end

`ifdef PAD_EVENT_REPEAT_EN
  localparam int         DIR_FIRST = BTN_UP;
  localparam int         NUM_DIR   = 4;
  localparam logic [5:0] RPT_FIRST = 6'd30;
  localparam logic [5:0] RPT_NEXT  = 6'd36;

  logic [NUM_DIR-1:0][5:0] rpt_cnt, rpt_cnt_nxt;

  // After the first repeat the counter parks at RPT_FIRST, so later repeats land every 6 held samples.
  always_comb begin
    rpt_hit     = '0;
    rpt_cnt_nxt = '0;
    for (int k = 0; k < NUM_DIR; k++) begin
      if (btn_state[DIR_FIRST+k] && !toggle[DIR_FIRST+k]) begin
        if ((rpt_cnt[k] + 6'd1 == RPT_FIRST) || (rpt_cnt[k] + 6'd1 == RPT_NEXT)) begin
          rpt_hit[DIR_FIRST+k] = 1'b1;
          rpt_cnt_nxt[k]       = RPT_FIRST;
        end else begin
          rpt_cnt_nxt[k] = rpt_cnt[k] + 6'd1;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      rpt_cnt <= '0;
    else if (accept)
      rpt_cnt <= rpt_cnt_nxt;
  end
`else
  assign rpt_hit = '0;
`endif

  assign scan_idx = lowest_set(pending);
  assign clr_mask = {{(NUM_BTN-1){1'b0}}, 1'b1} << scan_idx;
  assign evt_push = (state == ST_SCAN);
  assign evt      = make_evt(btn_state[scan_idx], rpt_flag[scan_idx], scan_idx);
  assign drop     = evt_push && fifo_full && !rd_en;
  assign ovf_set  = (sample_stb && (state == ST_SCAN)) || drop;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      btn_state <= '0;
      agree_cnt <= '0;
      pending   <= '0;
      rpt_flag  <= '0;
      overflow  <= 1'b0;
    end else begin
      if (accept) begin
        agree_cnt <= agree_cnt_nxt;
        btn_state <= btn_state ^ toggle;
        pending   <= toggle | rpt_hit;
        rpt_flag  <= rpt_hit & ~toggle;
        if (|(toggle | rpt_hit)) state <= ST_SCAN;
      end else if (state == ST_SCAN) begin
        pending  <= pending & ~clr_mask;
        rpt_flag <= rpt_flag & ~clr_mask;
        if ((pending & ~clr_mask) == '0) state <= ST_IDLE;
      end
      if (ovf_set)
        overflow <= 1'b1;
      else if (clr_ovf)
        overflow <= 1'b0;
    end
  end

  pad_evt_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (8)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (evt_push),
    .push_data (evt),
    .pop       (rd_en),
    .rd_data   (rd_data),
    .empty     (empty),
    .full      (fifo_full)
  );

endmodule
